// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - run-time programmable serial bit-pattern detector
//
// Purpose: watches a serial bit stream and flags the cycle in which the most
// recent len bits equal the programmed pattern. Pattern, length and overlap
// mode are loaded through a config strobe; reset defaults give the legacy
// overlapping 1011 detector. Output is Mealy (REG_OUT=0) or registered
// one cycle later (REG_OUT=1). A saturating counter tallies matches.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   i_cfg_we       config write strobe (loads pattern/len/overlap, clears history)
//   i_cfg_pattern  pattern, bit [len-1] first received, bit [0] last
//   i_cfg_len      pattern length (0 disables, > MAX_LEN clamps)
//   i_cfg_overlap  1 = overlapping matches allowed
//   i_valid        i_seq carries a bit this cycle
//   i_seq          serial data bit
//   i_cnt_clr      synchronous clear of the match counter (wins over increment)
//   o_det          match pulse
//   o_match_cnt    saturating match count
module seq_det_param #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8,
   parameter int REG_OUT = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_cfg_we,
   input  logic [MAX_LEN-1:0] i_cfg_pattern,
   input  logic [LEN_W-1:0]   i_cfg_len,
   input  logic               i_cfg_overlap,
   input  logic               i_valid,
   input  logic               i_seq,
   input  logic               i_cnt_clr,
   output logic               o_det,
   output logic [CNT_W-1:0]   o_match_cnt
);
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] FILL_ONE  = LEN_W'(1);
   localparam logic [LEN_W:0]   WIDE_ONE  = (LEN_W+1)'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [MAX_LEN-1:0] pattern;
   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] window;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   len;
   logic [LEN_W-1:0]   eff_len;
   logic [LEN_W-1:0]   fill;
   logic               overlap;
   logic               accept;
   logic               match;
   logic [CNT_W-1:0]   match_cnt;
   logic               unused_hist_msb;

   assign eff_len = (len > MAX_LEN_L) ? MAX_LEN_L : len;
   assign accept  = i_valid & ~i_cfg_we;

   // History as it will look after this cycle's shift; matching on it gives
   // the Mealy same-cycle response. The oldest stored bit falls off here.
   assign window          = {hist[MAX_LEN-2:0], i_seq};
   assign unused_hist_msb = hist[MAX_LEN-1];

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (LEN_W'(i) < eff_len);
      end
   end

   // fill counts bits before this one, so fill+1 bits are available now.
   assign match = accept
                  && (eff_len != '0)
                  && (({1'b0, fill} + WIDE_ONE) >= {1'b0, eff_len})
                  && (((window ^ pattern) & mask) == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern <= MAX_LEN'(4'b1011);
         len     <= LEN_W'(4);
         overlap <= 1'b1;
         hist    <= '0;
         fill    <= '0;
      end else if (i_cfg_we) begin
         pattern <= i_cfg_pattern;
         len     <= i_cfg_len;
         overlap <= i_cfg_overlap;
         hist    <= '0;
         fill    <= '0;
      end else if (accept) begin
         hist <= window;
         // Non-overlapping: forget the consumed bits so the next match
         // needs a full fresh pattern; history bits stay but are masked by fill.
         if (match && !overlap) begin
            fill <= '0;
         end else if (fill != MAX_LEN_L) begin
            fill <= fill + FILL_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_cnt <= '0;
      end else if (i_cnt_clr) begin
         match_cnt <= '0;
      end else if (match && (match_cnt != CNT_MAX)) begin
         match_cnt <= match_cnt + CNT_ONE;
      end
   end

   assign o_match_cnt = match_cnt;

   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic det_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               det_q <= 1'b0;
            end else begin
               det_q <= match;
            end
         end
         assign o_det = det_q;
      end else begin : g_mealy_out
         assign o_det = match & rst_n;
      end
   endgenerate
endmodule

// File: tb/tb_seq_det_param.sv
// tb/tb_seq_det_param.sv - directed self-checking bench for seq_det_param
module tb_seq_det_param;
   logic       clk;
   logic       rst_n;
   logic       cfg_we;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       valid;
   logic       seq;
   logic       cnt_clr;
   logic       det_m;
   logic [7:0] cnt_m;
   logic       det_r;
   logic [7:0] cnt_r;
   logic       det_s;
   logic [1:0] cnt_s;

   int n_checks = 0;
   int n_fail   = 0;

   seq_det_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .REG_OUT(0)) dut_m (
      .clk(clk), .rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_pattern(cfg_pattern),
      .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_valid(valid),
      .i_seq(seq), .i_cnt_clr(cnt_clr), .o_det(det_m), .o_match_cnt(cnt_m));

   seq_det_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .REG_OUT(1)) dut_r (
      .clk(clk), .rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_pattern(cfg_pattern),
      .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_valid(valid),
      .i_seq(seq), .i_cnt_clr(cnt_clr), .o_det(det_r), .o_match_cnt(cnt_r));

   seq_det_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2), .REG_OUT(0)) dut_s (
      .clk(clk), .rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_pattern(cfg_pattern),
      .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_valid(valid),
      .i_seq(seq), .i_cnt_clr(cnt_clr), .o_det(det_s), .o_match_cnt(cnt_s));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drive(input logic v, input logic s, input logic clr);
      @(negedge clk);
      cfg_we  = 1'b0;
      valid   = v;
      seq     = s;
      cnt_clr = clr;
      #2;
   endtask

   task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov);
      @(negedge clk);
      cfg_we      = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = ov;
      valid       = 1'b1;
      seq         = 1'b1;
      cnt_clr     = 1'b0;
      #2;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n   = 1'b0;
      cfg_we  = 1'b0;
      valid   = 1'b0;
      seq     = 1'b0;
      cnt_clr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_n = 1'b0;
      valid = 1'b1;
      seq   = 1'b1;
      #2;
      n_checks++;
      if (det_m !== 1'b0) begin n_fail++; $display("FAIL reset_det_m got %b want 0", det_m); end
      n_checks++;
      if (det_r !== 1'b0) begin n_fail++; $display("FAIL reset_det_r got %b want 0", det_r); end
      n_checks++;
      if (cnt_m !== 8'd0) begin n_fail++; $display("FAIL reset_cnt_m got %0d want 0", cnt_m); end
      n_checks++;
      if (cnt_s !== 2'd0) begin n_fail++; $display("FAIL reset_cnt_s got %0d want 0", cnt_s); end
      @(negedge clk);
      rst_n = 1'b1;
      valid = 1'b0;
   endtask

   task automatic test_overlap;
      logic [6:0] bits = 7'b1011011;
      logic [6:0] exp  = 7'b0001001;
      do_reset();
      for (int i = 6; i >= 0; i--) begin
         drive(1'b1, bits[i], 1'b0);
         n_checks++;
         if (det_m !== exp[i]) begin
            n_fail++; $display("FAIL ovl_det bit%0d got %b want %b", 7 - i, det_m, exp[i]);
         end
      end
      drive(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (cnt_m !== 8'd2) begin n_fail++; $display("FAIL ovl_cnt got %0d want 2", cnt_m); end
      n_checks++;
      if (det_m !== 1'b0) begin n_fail++; $display("FAIL ovl_idle_det got %b want 0", det_m); end
   endtask

   task automatic test_non_overlap;
      logic [6:0] bits = 7'b1011011;
      logic [6:0] exp  = 7'b0001000;
      do_reset();
      cfg(8'b0000_1011, 4'd4, 1'b0);
      for (int i = 6; i >= 0; i--) begin
         drive(1'b1, bits[i], 1'b0);
         n_checks++;
         if (det_m !== exp[i]) begin
            n_fail++; $display("FAIL novl_det bit%0d got %b want %b", 7 - i, det_m, exp[i]);
         end
      end
      drive(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (cnt_m !== 8'd1) begin n_fail++; $display("FAIL novl_cnt got %0d want 1", cnt_m); end
   endtask

   task automatic test_short_pattern;
      logic [3:0] exp_ovl  = 4'b0111;
      logic [3:0] exp_novl = 4'b0101;
      do_reset();
      cfg(8'b0000_0011, 4'd2, 1'b1);
      for (int i = 3; i >= 0; i--) begin
         drive(1'b1, 1'b1, 1'b0);
         n_checks++;
         if (det_m !== exp_ovl[i]) begin
            n_fail++; $display("FAIL short_ovl_det bit%0d got %b want %b", 4 - i, det_m, exp_ovl[i]);
         end
      end
      // Config cycle presents a 1 that would otherwise match 11.
      cfg(8'b0000_0011, 4'd2, 1'b0);
      n_checks++;
      if (det_m !== 1'b0) begin n_fail++; $display("FAIL short_cfg_det got %b want 0", det_m); end
      for (int i = 3; i >= 0; i--) begin
         drive(1'b1, 1'b1, 1'b0);
         if (i == 3) begin
            n_checks++;
            if (cnt_m !== 8'd3) begin n_fail++; $display("FAIL short_cnt_after_cfg got %0d want 3", cnt_m); end
         end
         n_checks++;
         if (det_m !== exp_novl[i]) begin
            n_fail++; $display("FAIL short_novl_det bit%0d got %b want %b", 4 - i, det_m, exp_novl[i]);
         end
      end
      drive(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (cnt_m !== 8'd5) begin n_fail++; $display("FAIL short_cnt got %0d want 5", cnt_m); end
   endtask

   task automatic test_reg_out;
      logic [8:0] v     = 9'b101010100;
      logic [8:0] s     = 9'b110111111;
      logic [8:0] exp_r = 9'b000000010;
      logic [8:0] exp_m = 9'b000000100;
      do_reset();
      for (int i = 8; i >= 0; i--) begin
         drive(v[i], s[i], 1'b0);
         n_checks++;
         if (det_r !== exp_r[i]) begin
            n_fail++; $display("FAIL regout_det_r step%0d got %b want %b", 8 - i, det_r, exp_r[i]);
         end
         n_checks++;
         if (det_m !== exp_m[i]) begin
            n_fail++; $display("FAIL regout_det_m step%0d got %b want %b", 8 - i, det_m, exp_m[i]);
         end
      end
      n_checks++;
      if (cnt_r !== 8'd1) begin n_fail++; $display("FAIL regout_cnt got %0d want 1", cnt_r); end
   endtask

   task automatic test_saturate;
      logic [15:0] bits = 16'b1011011011011011;
      do_reset();
      for (int i = 15; i >= 0; i--) begin
         drive(1'b1, bits[i], 1'b0);
      end
      drive(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (cnt_s !== 2'd3) begin n_fail++; $display("FAIL sat_cnt_s got %0d want 3", cnt_s); end
      n_checks++;
      if (cnt_m !== 8'd5) begin n_fail++; $display("FAIL sat_cnt_m got %0d want 5", cnt_m); end
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (det_s !== 1'b1) begin n_fail++; $display("FAIL sat_clr_det got %b want 1", det_s); end
      drive(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (cnt_s !== 2'd0) begin n_fail++; $display("FAIL sat_clr_cnt_s got %0d want 0", cnt_s); end
      n_checks++;
      if (cnt_m !== 8'd0) begin n_fail++; $display("FAIL sat_clr_cnt_m got %0d want 0", cnt_m); end
   endtask

   task automatic test_interrupt;
      logic [6:0] bits  = 7'b1011011;
      logic [7:0] cbits = 8'b10110011;
      logic [7:0] cexp  = 8'b00000001;
      do_reset();
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      // Async reset between edges must clear the counter at once.
      @(posedge clk);
      #2 rst_n = 1'b0;
      valid = 1'b0;
      #1;
      n_checks++;
      if (cnt_m !== 8'd0) begin n_fail++; $display("FAIL midrst_cnt got %0d want 0", cnt_m); end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (det_m !== 1'b0) begin n_fail++; $display("FAIL midrst_det got %b want 0", det_m); end

      do_reset();
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      cfg(8'b0000_1011, 4'd4, 1'b1);
      n_checks++;
      if (det_m !== 1'b0) begin n_fail++; $display("FAIL cfgwr_det got %b want 0", det_m); end
      drive(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (det_m !== 1'b0) begin n_fail++; $display("FAIL cfgwr_after_det got %b want 0", det_m); end
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (det_m !== 1'b1) begin n_fail++; $display("FAIL cfgwr_fresh_det got %b want 1", det_m); end

      cfg(8'b0000_1011, 4'd0, 1'b1);
      for (int i = 6; i >= 0; i--) begin
         drive(1'b1, bits[i], 1'b0);
         n_checks++;
         if (det_m !== 1'b0) begin
            n_fail++; $display("FAIL len0_det bit%0d got %b want 0", 7 - i, det_m);
         end
      end
      drive(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (cnt_m !== 8'd1) begin n_fail++; $display("FAIL len0_cnt got %0d want 1", cnt_m); end

      cfg(8'b10110011, 4'd15, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         drive(1'b1, cbits[i], 1'b0);
         n_checks++;
         if (det_m !== cexp[i]) begin
            n_fail++; $display("FAIL clamp_det bit%0d got %b want %b", 8 - i, det_m, cexp[i]);
         end
      end
      drive(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (cnt_m !== 8'd2) begin n_fail++; $display("FAIL clamp_cnt got %0d want 2", cnt_m); end
   endtask

   initial begin
      rst_n       = 1'b0;
      cfg_we      = 1'b0;
      cfg_pattern = 8'd0;
      cfg_len     = 4'd0;
      cfg_overlap = 1'b0;
      valid       = 1'b0;
      seq         = 1'b0;
      cnt_clr     = 1'b0;
      test_reset();
      test_overlap();
      test_non_overlap();
      test_short_pattern();
      test_reg_out();
      test_saturate();
      test_interrupt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised serial bit-pattern detector. It succeeds the fixed 1011 Mealy detector and can be reprogrammed at run time.
- Pattern and length are loaded through a config strobe.
- Overlapping or non-overlapping matching is selectable.
- Output timing is selectable at build time: Mealy (same cycle) or registered (one cycle later).
- A saturating match counter is included.
It sits on a serial bit stream behind a sampling stage and flags frame/sync words.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
LEN_W, 4, width of length field; must hold MAX_LEN (clog2(MAX_LEN)+1)
CNT_W, 8, match counter width
REG_OUT, 0, 0 = Mealy o_det (combinational from i_seq), 1 = o_det registered (one cycle later)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
i_cfg_we  in  1  config write strobe
i_cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first received bit, bit [0] the last
i_cfg_len  in  LEN_W  pattern length
i_cfg_overlap  in  1  1 = overlapping matches allowed
i_valid  in  1  i_seq carries a bit this cycle
i_seq  in  1  serial data bit
i_cnt_clr  in  1  synchronous clear of match counter
o_det  out  1  match pulse
o_match_cnt  out  CNT_W  saturating number of matches

Behaviour:
- Reset (async, rst_n=0):
  - pattern = 1011 in low bits, upper bits 0.
  - len = 4, overlap = 1.
  - History register = 0, fill count = 0.
  - o_det = 0 (REG_OUT=1 flop; REG_OUT=0 output forced 0 while in reset).
  - o_match_cnt = 0.
  - Reset defaults reproduce the legacy 1011 overlapping detector.
- Internal state:
  - hist[MAX_LEN-1:0]: received bits, newest at bit 0.
  - fill: saturates at MAX_LEN, counts bits received since the last clear.
- Accepted bit: i_valid=1 and i_cfg_we=0.
  - hist <= {hist[MAX_LEN-2:0], i_seq}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition (evaluated on the post-shift history):
  - len >= 1 and fill+1 >= len;
  - low len bits of {hist,i_seq} equal pattern[len-1:0].
- Effective length:
  - len = 0 disables detection; o_det stays 0 and the counter is frozen.
  - len > MAX_LEN clamps to MAX_LEN.
- On a match:
  - overlap=1: history retained, so the suffix may begin the next match.
  - overlap=0: fill cleared to 0 at the clock edge, so the next match needs len fresh bits.
- o_det timing:
  - REG_OUT=0: o_det = match, combinational, asserted during the cycle the final bit is presented.
  - REG_OUT=1: o_det is match registered; it is high for exactly the one cycle after the final-bit cycle.
- i_valid=0: no shift, no match, o_det=0 (Mealy) / 0 on the next cycle (registered).
- Config write (i_cfg_we=1):
  - pattern/len/overlap load at the edge.
  - hist and fill clear.
  - i_seq is ignored that cycle, with no match.
  - Counter is not affected.
- Counter:
  - Increments by 1 on each match edge; saturates at 2^CNT_W-1, with no wrap.
  - i_cnt_clr has priority over an increment in the same cycle (result 0).
- Reset mid-stream: all state returns to defaults immediately; any partial match is lost.
- o_det never asserts on bits that straddle a config write or a reset.

Test Plan:
1. Reset defaults, REG_OUT=0, stream 1011011 one bit/cycle with i_valid=1 -> o_det high in the cycles of bits 4 and 7; o_match_cnt=2.
2. Configure pattern=1011, len=4, overlap=0, same stream 1011011 -> o_det only at bit 4; o_match_cnt=1.
3. Configure pattern=11, len=2; stream 1111.
   - overlap=1 -> matches at bits 2, 3, 4; count 3.
   - overlap=0 -> matches at bits 2 and 4; count 2.
4. REG_OUT=1, defaults, stream 1011 with i_valid gaps (valid on alternate cycles) -> single o_det pulse one cycle after the 4th valid bit; no pulse on gap cycles.
5. CNT_W=2, default pattern, stream 1011 repeated 5 times (overlap=1) -> count saturates at 3. Then assert i_cnt_clr together with a matching bit -> count=0.
6. Stream 101, pulse rst_n low mid-cycle, then stream 1 -> no o_det. Also: config write after 101, then 1 -> no o_det; len=0 -> o_det never asserts.
